// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg
// Shared types and helpers for the immediate decode stage:
//   - opcode enumeration and instruction field positions
//   - decoded bundle layout carried through the skid buffer
//   - skid buffer occupancy states
//   - decode_ctrl / decode_instr: combinational opcode decode
package imm_decode_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [FIELD_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_LDR  = 4'd6,
    OP_STR  = 4'd7,
    OP_B    = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic use_imm;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] imm4;
    logic               use_imm;
    logic               illegal;
  } bundle_t;

  localparam int unsigned BUNDLE_W = $bits(bundle_t);

  // Operand-B source and legality for one opcode.
  function automatic ctrl_t decode_ctrl(input logic [FIELD_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (opcode_e'(opc))
      OP_ADD, OP_SUB, OP_AND, OP_OR:               c.use_imm = 1'b0;
      OP_ADDI, OP_SUBI, OP_LDR, OP_STR, OP_B:      c.use_imm = 1'b1;
      default:                                     c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Split an instruction word into the decoded bundle.
  function automatic bundle_t decode_instr(input logic [INSTR_W-1:0] instr);
    bundle_t b;
    ctrl_t   c;
    b.opcode  = instr[OPC_LSB +: FIELD_W];
    b.rd      = instr[RD_LSB  +: FIELD_W];
    b.rs      = instr[RS_LSB  +: FIELD_W];
    b.imm4    = instr[IMM_LSB +: FIELD_W];
    c         = decode_ctrl(b.opcode);
    b.use_imm = c.use_imm;
    b.illegal = c.illegal;
    return b;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if
// Upstream instruction handshake plus downstream decoded-bundle handshake.
//   master: drives in_valid/in_instr/out_ready, observes the rest
//   slave : the decode stage; drives in_ready and all out_* fields
interface imm_decode_stage_if;
  import imm_decode_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_opcode;
  logic [FIELD_W-1:0] out_rd;
  logic [FIELD_W-1:0] out_rs;
  logic [FIELD_W-1:0] out_imm4;
  logic               out_use_imm;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_imm4,
           out_use_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs, out_imm4,
           out_use_imm, out_illegal
  );

endinterface

// File: rtl/imm_decode_stage_skid_buffer.sv
// imm_decode_stage_skid_buffer
// Two-entry valid/ready register slice with a generic payload.
// in_ready_o is a flop, so there is no path from out_ready_i to in_ready_o;
// the skid entry absorbs the word accepted while the output stalls.
//   clock, reset_n        : clock, async active-low reset
//   in_valid_i/in_ready_o : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_data_o payload
module imm_decode_stage_skid_buffer
  import imm_decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy transitions and data movement.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    skid_d   = skid_q;
    in_xfer  = in_valid_i && ready_q;
    out_xfer = valid_q && out_ready_i;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_d   = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = in_data_i;
        end else if (in_xfer) begin
          skid_d  = in_data_i;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_q is low here, so only the drain can happen.
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flags track the next state so they stay in step with state_q.
    ready_d = (state_d != ST_FULL);
    valid_d = (state_d != ST_EMPTY);
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Decodes 16-bit instruction words (opcode/rd/rs/imm4) in front of a
// two-entry skid buffer and presents the decoded bundle downstream.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : in_valid/in_ready/in_instr, out_valid/out_ready and
//                    out_opcode/out_rd/out_rs/out_imm4/out_use_imm/out_illegal
//   instr_count    : bundles accepted downstream (wraps)
//   illegal_seen   : sticky, an illegal opcode went through
// Build option DECODE_ILLEGAL_DROP_EN: illegal words are swallowed at the
// input (still handshaken), flagged in illegal_seen, and never forwarded.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  imm_decode_stage_if.slave  bus,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal_seen
);

  bundle_t             dec_c;
  bundle_t             out_bundle;
  logic [BUNDLE_W-1:0] push_data;
  logic [BUNDLE_W-1:0] pop_data;
  logic                push_valid;
  logic                out_xfer;
  logic                seen_set;
  logic [COUNT_W-1:0]  instr_count_q;
  logic                illegal_seen_q;

  // Combinational decode ahead of the register slice.
  assign dec_c     = decode_instr(bus.in_instr);
  assign push_data = dec_c;

`ifdef DECODE_ILLEGAL_DROP_EN
  // Illegal words are handshaken upstream but never enter the buffer.
  assign push_valid = bus.in_valid && !dec_c.illegal;
  assign seen_set   = bus.in_valid && bus.in_ready && dec_c.illegal;
`else
  assign push_valid = bus.in_valid;
  assign seen_set   = out_xfer && out_bundle.illegal;
`endif

  imm_decode_stage_skid_buffer #(
    .WIDTH (BUNDLE_W)
  ) u_skid (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid_i  (push_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (push_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (pop_data)
  );

  assign out_bundle      = bundle_t'(pop_data);
  assign bus.out_opcode  = out_bundle.opcode;
  assign bus.out_rd      = out_bundle.rd;
  assign bus.out_rs      = out_bundle.rs;
  assign bus.out_imm4    = out_bundle.imm4;
  assign bus.out_use_imm = out_bundle.use_imm;
  assign bus.out_illegal = out_bundle.illegal;

  assign out_xfer = bus.out_valid && bus.out_ready;

  // Delivered-bundle counter and sticky illegal flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count_q  <= '0;
      illegal_seen_q <= 1'b0;
    end else begin
      if (out_xfer) begin
        instr_count_q <= instr_count_q + COUNT_W'(1);
      end
      if (seen_set) begin
        illegal_seen_q <= 1'b1;
      end
    end
  end

  assign instr_count  = instr_count_q;
  assign illegal_seen = illegal_seen_q;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameters: none; instruction width fixed at 16, immediate field fixed at 4.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream instruction word present.
REQ-005 in_ready  output  1  stage can accept a word this cycle; registered.
REQ-006 in_instr  input  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-007 out_valid  output  1  decoded bundle present.
REQ-008 out_ready  input  1  downstream (sign-extend/execute) accepts bundle.
REQ-009 out_opcode  output  4, out_rd  output  4, out_rs  output  4: copied fields.
REQ-010 out_imm4  output  4  raw bits [3:0]; feeds the 4-to-16 sign extender's inp.
REQ-011 out_use_imm  output  1  operand B comes from extended imm4, not register rt.
REQ-012 out_illegal  output  1  opcode not in the decode table.
REQ-013 instr_count  output  16  number of bundles accepted downstream.
REQ-014 illegal_seen  output  1  sticky flag, set when any illegal opcode is accepted.

Function
REQ-015 Decode table: 0 ADD, 1 SUB, 2 AND, 3 OR (use_imm=0); 4 ADDI, 5 SUBI, 6 LDR, 7 STR, 8 B (use_imm=1); 9-15 illegal.
REQ-016 Input transfer occurs on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-017 Latency: a word accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1 when the stage was empty.
REQ-018 FSM states: EMPTY (no entries), ONE (output register full), FULL (output register and skid register full).
REQ-019 EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input transfer; ONE->FULL on input transfer without output transfer; ONE->ONE on both; FULL->ONE on output transfer, when skid moves to the output register.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; no combinational path from out_ready to in_ready.
REQ-021 Output bundle fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Order preserved; no word dropped or duplicated (except REQ-027).
REQ-023 instr_count increments by 1 per output transfer, wrapping 16'hFFFF->16'h0000.
REQ-024 illegal_seen is set on output transfer of a bundle with out_illegal=1 and cleared only by reset.

Reset
REQ-025 reset_n low forces immediately: state EMPTY, out_valid=0, in_ready=0 while asserted then 1 on the first clock after release, all out_* fields 0, instr_count=0, illegal_seen=0.
REQ-026 Reset mid-operation discards both held entries; no transfer is reported for them.

Configuration
REQ-027 Macro DECODE_ILLEGAL_DROP_EN: when defined, illegal words are accepted (in_ready unaffected), never presented downstream, not counted, but set illegal_seen at acceptance; when undefined, illegal words pass through with out_illegal=1 per REQ-024.

Structure
REQ-028 Shared package holds opcode enum, field-position constants, and the use_imm/illegal decode function.
REQ-029 One sub-module: skid_buffer (two-entry handshake register, generic payload width); decode is combinational in front of it.

Verification
REQ-030 After reset, in_valid=1, in_instr=16'h4125, out_ready=1 -> next cycle out_valid=1, opcode=4, rd=1, rs=2, imm4=5, use_imm=1, then instr_count=1.
REQ-031 out_ready=0, push 16'h0123 and 16'h1456 back-to-back -> FULL, in_ready=0; third word held; raise out_ready -> 0123 then 1456 delivered in order.
REQ-032 Stream 4 words with out_ready toggling every cycle -> all 4 delivered in order, fields stable while stalled, instr_count=4.
REQ-033 in_instr=16'hF000 -> out_illegal=1 and illegal_seen=1 (macro off); with macro on, nothing delivered, instr_count unchanged, illegal_seen=1.
REQ-034 Preload instr_count to 16'hFFFF via 65535 transfers, one more transfer -> instr_count=16'h0000.
REQ-035 Assert reset_n=0 in FULL state -> out_valid=0 and outputs 0 without a clock edge; after release, first new word appears with no stale data.
